// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of all non-clock/reset signals of the register-file write-back
// controller.
//   master : the pipeline side. It drives the ALU result, load issue, memory
//            response and decode operands.
//   slave  : the controller. It drives load-queue status, the memory response
//            ready, the decode hazard and the register-file write port.
interface regfile_wb_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 4
);
  logic                           alu_valid;
  logic [4:0]                     alu_rd;
  logic [XLEN-1:0]                alu_result;
  logic                           ld_issue_valid;
  logic                           ld_issue_ready;
  logic [4:0]                     ld_rd;
  logic [2:0]                     ld_funct3;
  logic [1:0]                     ld_offset;
  logic                           mem_rvalid;
  logic                           mem_rready;
  logic [XLEN-1:0]                mem_rdata;
  logic [4:0]                     dec_rs1;
  logic [4:0]                     dec_rs2;
  logic [4:0]                     dec_rd;
  logic                           hazard_stall;
  logic [$clog2(LDQ_DEPTH):0]     ld_pending;
  logic                           reg_wr;
  logic [4:0]                     waddr;
  logic [XLEN-1:0]                wdata;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_issue_valid, ld_rd, ld_funct3, ld_offset,
    output mem_rvalid, mem_rdata,
    output dec_rs1, dec_rs2, dec_rd,
    input  ld_issue_ready, mem_rready, hazard_stall, ld_pending,
    input  reg_wr, waddr, wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_issue_valid, ld_rd, ld_funct3, ld_offset,
    input  mem_rvalid, mem_rdata,
    input  dec_rs1, dec_rs2, dec_rd,
    output ld_issue_ready, mem_rready, hazard_stall, ld_pending,
    output reg_wr, waddr, wdata
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller.
// It merges single-cycle ALU results with in-order load responses. Each load
// response is aligned and sign/zero-extended according to the load type.
// Outstanding loads are tracked in a FIFO, and decode-stage hazards are
// flagged against them.
// Ports:
//   clk_i  : clock; all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of regfile_wb_ctrl_if (see the interface file)
module regfile_wb_ctrl #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  regfile_wb_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(LDQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Load queue storage
  logic [4:0]           q_rd_q  [LDQ_DEPTH];
  logic [2:0]           q_f3_q  [LDQ_DEPTH];
  logic [1:0]           q_off_q [LDQ_DEPTH];
  logic [LDQ_DEPTH-1:0] q_vld_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  // Skid register for a load response displaced by an ALU write
  logic                 skid_valid_q, skid_valid_d;
  logic [4:0]           skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]      skid_data_q, skid_data_d;

  // Registered write port
  logic                 reg_wr_q, reg_wr_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;

  logic                 full_s, empty_s, push_s, pop_s;
  logic [XLEN-1:0]      ld_data_s;
  logic                 hazard_s;
  logic                 sel_s;
  logic [4:0]           sel_rd_s;
  logic [XLEN-1:0]      sel_data_s;

  // Align and extend a raw memory word according to the load type.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // True when a nonzero rd matches any decode-stage operand.
  function automatic logic dec_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] drd);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2) || (rd == drd));
  endfunction

  assign full_s  = (count_q == CNT_W'(LDQ_DEPTH));
  assign empty_s = (count_q == CNT_W'(0));
  // A full queue never accepts a push, even when the head pops this cycle.
  assign push_s  = bus.ld_issue_valid && !full_s;
  // Responses are blocked while the skid register holds a load result.
  assign pop_s   = bus.mem_rvalid && !empty_s && !skid_valid_q;
  assign ld_data_s = load_extract(q_f3_q[rd_ptr_q], q_off_q[rd_ptr_q], bus.mem_rdata);

  // Write arbitration: ALU, then skid, then the accepted load response.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    sel_s        = 1'b0;
    sel_rd_s     = 5'd0;
    sel_data_s   = '0;
    if (bus.alu_valid) begin
      sel_s      = 1'b1;
      sel_rd_s   = bus.alu_rd;
      sel_data_s = bus.alu_result;
      if (pop_s) begin
        skid_valid_d = 1'b1;
        skid_rd_d    = q_rd_q[rd_ptr_q];
        skid_data_d  = ld_data_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (skid_valid_q) begin
      sel_s        = 1'b1;
      sel_rd_s     = skid_rd_q;
      sel_data_s   = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (pop_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = q_rd_q[rd_ptr_q];
      sel_data_s = ld_data_s;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Next write-port values; an x0 destination consumes the source without writing.
  always_comb begin
    reg_wr_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (sel_s) begin
      reg_wr_d = (sel_rd_s != 5'd0);
      waddr_d  = sel_rd_s;
      wdata_d  = sel_data_s;
    end else begin
      reg_wr_d = 1'b0;
    end
  end

  // Occupancy update from push and pop.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Decode hazard against valid queue entries and the skid register.
  always_comb begin
    hazard_s = skid_valid_q && dec_hit(skid_rd_q, bus.dec_rs1, bus.dec_rs2, bus.dec_rd);
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (q_vld_q[i] && dec_hit(q_rd_q[i], bus.dec_rs1, bus.dec_rs2, bus.dec_rd)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Load queue storage, pointers and valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        q_rd_q[i]  <= 5'd0;
        q_f3_q[i]  <= 3'd0;
        q_off_q[i] <= 2'd0;
      end
      q_vld_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (pop_s) begin
        q_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      if (push_s) begin
        q_rd_q[wr_ptr_q]  <= bus.ld_rd;
        q_f3_q[wr_ptr_q]  <= bus.ld_funct3;
        q_off_q[wr_ptr_q] <= bus.ld_offset;
        q_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Skid register and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid_q <= 1'b0;
      skid_rd_q    <= 5'd0;
      skid_data_q  <= '0;
      reg_wr_q     <= 1'b0;
      waddr_q      <= 5'd0;
      wdata_q      <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      reg_wr_q     <= reg_wr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.ld_issue_ready = !full_s;
  assign bus.mem_rready     = !empty_s && !skid_valid_q;
  assign bus.hazard_stall   = hazard_s;
  assign bus.ld_pending     = count_q + CNT_W'(skid_valid_q);
  assign bus.reg_wr         = reg_wr_q;
  assign bus.waddr          = waddr_q;
  assign bus.wdata          = wdata_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a table of single-cycle vectors
// followed by hand-written sequences for skid, full-queue and reset cases.
module tb_regfile_wb_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_ctrl_if #(.XLEN(32), .LDQ_DEPTH(4)) bus ();

  regfile_wb_ctrl #(.XLEN(32), .LDQ_DEPTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_issue_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        exp_wr;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_pend;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk_idle(input logic [2:0] pend);
    vec_t v;
    v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0,
          1'b0, 5'd0, 32'd0, pend};
    return v;
  endfunction

  function automatic vec_t mk_alu(input logic [4:0] rd, input logic [31:0] d);
    vec_t v;
    v = mk_idle(3'd0);
    v.alu_valid = 1'b1; v.alu_rd = rd; v.alu_result = d;
    v.exp_wr = 1'b1; v.exp_waddr = rd; v.exp_wdata = d;
    return v;
  endfunction

  function automatic vec_t mk_ld(input logic [4:0] rd, input logic [2:0] f3,
                                 input logic [1:0] off);
    vec_t v;
    v = mk_idle(3'd1);
    v.ld_issue_valid = 1'b1; v.ld_rd = rd; v.ld_funct3 = f3; v.ld_offset = off;
    return v;
  endfunction

  function automatic vec_t mk_rsp(input logic [31:0] raw, input logic ew,
                                  input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v = mk_idle(3'd0);
    v.mem_rvalid = 1'b1; v.mem_rdata = raw;
    v.exp_wr = ew; v.exp_waddr = ea; v.exp_wdata = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_result = 32'd0;
    bus.ld_issue_valid = 1'b0; bus.ld_rd = 5'd0; bus.ld_funct3 = 3'd0; bus.ld_offset = 2'd0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    bus.ld_issue_valid = 1'b1; bus.ld_rd = rd; bus.ld_funct3 = f3; bus.ld_offset = off;
    tick();
    bus.ld_issue_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk_alu(5'd5, 32'h0000_1234);
    vecs[1]  = mk_ld(5'd7, 3'b000, 2'd2);
    vecs[2]  = mk_rsp(32'h00A5_0000, 1'b1, 5'd7, 32'hFFFF_FFA5);
    vecs[3]  = mk_ld(5'd7, 3'b100, 2'd2);
    vecs[4]  = mk_rsp(32'h00A5_0000, 1'b1, 5'd7, 32'h0000_00A5);
    vecs[5]  = mk_ld(5'd9, 3'b010, 2'd0);
    vecs[6]  = mk_rsp(32'hCAFE_F00D, 1'b1, 5'd9, 32'hCAFE_F00D);
    vecs[7]  = mk_ld(5'd10, 3'b101, 2'd0);
    vecs[8]  = mk_rsp(32'h1234_ABCD, 1'b1, 5'd10, 32'h0000_ABCD);
    vecs[9]  = mk_ld(5'd11, 3'b000, 2'd3);
    vecs[10] = mk_rsp(32'h7F00_0000, 1'b1, 5'd11, 32'h0000_007F);
    vecs[11] = mk_ld(5'd12, 3'b011, 2'd1);
    vecs[12] = mk_rsp(32'h89AB_CDEF, 1'b1, 5'd12, 32'h89AB_CDEF);
    vecs[13] = mk_ld(5'd13, 3'b001, 2'd0);
    vecs[14] = mk_rsp(32'h0000_FFFE, 1'b1, 5'd13, 32'hFFFF_FFFE);
    vecs[15] = mk_idle(3'd0);
    vecs[16] = mk_ld(5'd0, 3'b010, 2'd0);
    vecs[17] = mk_rsp(32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);

    idle_inputs();
    rst_ni = 1'b0;
    #1;
    chk("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_pending", 32'(bus.ld_pending), 32'd0);
    chk("rst_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
    chk("rst_mem_rready", 32'(bus.mem_rready), 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 18; i++) begin
      bus.alu_valid = vecs[i].alu_valid; bus.alu_rd = vecs[i].alu_rd;
      bus.alu_result = vecs[i].alu_result;
      bus.ld_issue_valid = vecs[i].ld_issue_valid; bus.ld_rd = vecs[i].ld_rd;
      bus.ld_funct3 = vecs[i].ld_funct3; bus.ld_offset = vecs[i].ld_offset;
      bus.mem_rvalid = vecs[i].mem_rvalid; bus.mem_rdata = vecs[i].mem_rdata;
      tick();
      chk($sformatf("v%0d_reg_wr", i), 32'(bus.reg_wr), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_pending", i), 32'(bus.ld_pending), 32'(vecs[i].exp_pend));
      if (vecs[i].exp_wr) begin
        chk($sformatf("v%0d_waddr", i), 32'(bus.waddr), 32'(vecs[i].exp_waddr));
        chk($sformatf("v%0d_wdata", i), bus.wdata, vecs[i].exp_wdata);
      end
    end
    idle_inputs();
    tick();

    // ALU write and load response in the same cycle: load goes through skid
    issue(5'd3, 3'b001, 2'd2);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_result = 32'h0000_0055;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8001_0000;
    #1;
    chk("skid_rready_before", 32'(bus.mem_rready), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("skid_n1_reg_wr", 32'(bus.reg_wr), 32'd1);
    chk("skid_n1_waddr", 32'(bus.waddr), 32'd4);
    chk("skid_n1_wdata", bus.wdata, 32'h0000_0055);
    chk("skid_n1_rready", 32'(bus.mem_rready), 32'd0);
    chk("skid_n1_pending", 32'(bus.ld_pending), 32'd1);
    bus.dec_rd = 5'd3;
    #1;
    chk("skid_hazard", 32'(bus.hazard_stall), 32'd1);
    bus.dec_rd = 5'd0;
    tick();
    chk("skid_n2_reg_wr", 32'(bus.reg_wr), 32'd1);
    chk("skid_n2_waddr", 32'(bus.waddr), 32'd3);
    chk("skid_n2_wdata", bus.wdata, 32'hFFFF_8001);
    chk("skid_n2_pending", 32'(bus.ld_pending), 32'd0);
    tick();
    chk("skid_n3_reg_wr", 32'(bus.reg_wr), 32'd0);
    chk("hold_waddr", 32'(bus.waddr), 32'd3);

    // Fill the queue, check hazards, then push-while-full with a pop
    for (int k = 0; k < 4; k++) issue(5'(20 + k), 3'b010, 2'd0);
    chk("full_ready", 32'(bus.ld_issue_ready), 32'd0);
    chk("full_pending", 32'(bus.ld_pending), 32'd4);
    bus.dec_rs2 = 5'd21;
    #1;
    chk("full_hazard_rs2", 32'(bus.hazard_stall), 32'd1);
    bus.dec_rs2 = 5'd0; bus.dec_rs1 = 5'd0;
    #1;
    chk("x0_no_hazard", 32'(bus.hazard_stall), 32'd0);
    bus.ld_issue_valid = 1'b1; bus.ld_rd = 5'd24; bus.ld_funct3 = 3'b010;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.ld_issue_valid = 1'b0;
    chk("full_pop_waddr", 32'(bus.waddr), 32'd20);
    chk("full_pop_wdata", bus.wdata, 32'h1111_1111);
    chk("full_nopush_pending", 32'(bus.ld_pending), 32'd3);
    for (int k = 1; k < 4; k++) begin
      bus.mem_rdata = 32'(k) * 32'h0101_0101;
      tick();
      chk($sformatf("drain%0d_waddr", k), 32'(bus.waddr), 32'(20 + k));
      chk($sformatf("drain%0d_wdata", k), bus.wdata, 32'(k) * 32'h0101_0101);
    end
    idle_inputs();
    bus.dec_rs2 = 5'd21;
    #1;
    chk("drain_hazard", 32'(bus.hazard_stall), 32'd0);
    chk("drain_ready", 32'(bus.ld_issue_ready), 32'd1);
    chk("drain_pending", 32'(bus.ld_pending), 32'd0);
    bus.dec_rs2 = 5'd0;

    // Asynchronous reset with three loads pending
    issue(5'd14, 3'b010, 2'd0);
    issue(5'd15, 3'b010, 2'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_result = 32'h0000_0066;
    issue(5'd16, 3'b010, 2'd0);
    bus.alu_valid = 1'b0;
    chk("pre_rst_pending", 32'(bus.ld_pending), 32'd3);
    chk("pre_rst_reg_wr", 32'(bus.reg_wr), 32'd1);
    bus.dec_rs1 = 5'd15;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_pending", 32'(bus.ld_pending), 32'd0);
    chk("mid_rst_reg_wr", 32'(bus.reg_wr), 32'd0);
    chk("mid_rst_hazard", 32'(bus.hazard_stall), 32'd0);
    tick();
    rst_ni = 1'b1;
    bus.dec_rs1 = 5'd0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    #1;
    chk("stray_rready", 32'(bus.mem_rready), 32'd0);
    tick();
    chk("stray_reg_wr", 32'(bus.reg_wr), 32'd0);
    chk("stray_pending", 32'(bus.ld_pending), 32'd0);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Drives the write port of the pipeline's 32x32 register file: reg_wr, waddr and wdata.
- Merges two write sources:
  - single-cycle ALU results;
  - in-order, multi-cycle load responses from data memory, aligned and sign- or zero-extended.
- Tracks outstanding loads in a small queue and flags decode-stage hazards against them.

Parameters:
XLEN, 32, datapath width
LDQ_DEPTH, 4, maximum outstanding loads (power of two, >=2)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result available this cycle
alu_rd  in  5  ALU destination register
alu_result  in  XLEN  ALU result
ld_issue_valid  in  1  load issued to memory this cycle
ld_issue_ready  out  1  load queue can accept an issue
ld_rd  in  5  load destination register
ld_funct3  in  3  load type
ld_offset  in  2  address bits [1:0]
mem_rvalid  in  1  load response valid
mem_rready  out  1  controller accepts the load response
mem_rdata  in  XLEN  raw aligned word from memory
dec_rs1  in  5  decode-stage source 1
dec_rs2  in  5  decode-stage source 2
dec_rd  in  5  decode-stage destination
hazard_stall  out  1  decode must stall
ld_pending  out  $clog2(LDQ_DEPTH)+1  queue occupancy
reg_wr  out  1  register file write enable
waddr  out  5  register file write address
wdata  out  XLEN  register file write data

Behaviour:
- Reset (rst low, asynchronous):
  - queue emptied, skid register invalid;
  - reg_wr=0, waddr=0, wdata=0, ld_pending=0;
  - a reset mid-operation discards all outstanding loads.
- Load queue:
  - FIFO of {rd, funct3, offset}; ld_issue_ready = !full.
  - Push on ld_issue_valid && ld_issue_ready. No push when full, even if a pop occurs the same cycle.
- Response handshake:
  - mem_rready = (queue not empty) && !skid_valid.
  - Pop the head on mem_rvalid && mem_rready.
  - mem_rvalid while the queue is empty is ignored; nothing is written.
- Extraction, byte lane selected by the head entry's offset:
  - 000 LB: byte, sign-extended.
  - 001 LH: half selected by offset[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half selected by offset[1], zero-extended.
  - Any other funct3: raw word.
- Write arbitration, evaluated each cycle; outputs registered on the next posedge (latency 1):
  1. alu_valid: write the ALU result. A load response accepted in the same cycle is stored in the skid register.
  2. else skid_valid: write the skid contents and clear skid_valid.
  3. else load response accepted: write the load result.
  4. else reg_wr=0; waddr and wdata hold their previous values.
- x0: any selected write with rd==0 gives reg_wr=0. The source is still consumed (queue popped, skid cleared).
- hazard_stall (combinational) = 1 when any nonzero register among dec_rs1, dec_rs2, dec_rd matches the rd of:
  - a valid queue entry, or
  - the skid register.
- The registered output stage is excluded from hazard_stall: the register file writes on negedge, before decode's read.
- ALU RAW hazards are not checked here; forwarding covers them.
- ld_pending = queue count + skid_valid.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo LDQ_DEPTH.

Test Plan:
- Reset release, then alu_valid=1, alu_rd=5, alu_result=0x1234 -> next cycle reg_wr=1, waddr=5, wdata=0x1234.
- Issue LB rd=7 offset=2; response mem_rdata=0x00A50000 -> wdata=0xFFFFFFA5, waddr=7. Repeat as LBU -> wdata=0x000000A5.
- Issue LH rd=3 offset=2 with a response 0x80010000 in the same cycle as an ALU write to rd=4:
  - cycle N+1: waddr=4;
  - cycle N+2: waddr=3, wdata=0xFFFF8001;
  - mem_rready=0 during N+1.
- Issue LDQ_DEPTH=4 loads with no response -> ld_issue_ready=0, ld_pending=4. Then dec_rs2 equal to the 2nd queued rd -> hazard_stall=1. Drain all four -> hazard_stall=0, ld_issue_ready=1.
- Load with rd=0 and response 0xDEADBEEF -> reg_wr stays 0, ld_pending returns to 0. dec_rs1=0 never stalls.
- Assert rst low with 3 loads pending -> immediately ld_pending=0, reg_wr=0, hazard_stall=0. A stray mem_rvalid after release -> mem_rready=0, no write.
